// File: rtl/uart_receiver.sv
// UART receiver: oversampled 8N1/8E1 deframer feeding a small byte FIFO, with
// RXDATA/CTRL/STATUS registers on the core data bus and a level interrupt.
module uart_receiver #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [19:0] BASE_PAGE    = 20'h00024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        irq,
  input  logic        rx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] CNT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] CNT_MID  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_par_err(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(FIFO_DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  logic          sync1_q, sync2_q, sync1_d, sync2_d;
  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_q, perr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic          par_err_q, par_err_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic          gnt_q, gnt_d, rvalid_q, rvalid_d, irq_q, irq_d;
  logic [31:0]   rdata_q, rdata_d;

  logic        rx_s, access_s, rd_acc_s, wr_acc_s, empty_s, full_s, pop_s, push_s, w1c_s;
  logic        stop_eval_s, stop_ok_s, stop_fe_s, stop_pe_s, ov_set_s;
  logic [9:0]  off_s;
  logic [2:0]  cnt3_s;
  logic [31:0] rd_val_s;
  logic        unused_s;

  assign rx_s        = sync2_q;
  assign data_gnt    = gnt_q;
  assign data_rvalid = rvalid_q;
  assign data_rdata  = rdata_q;
  assign irq         = irq_q;
  assign unused_s    = ^{data_wdata[31:5], data_addr[1:0], data_be[3:1]};

  // Bus decode and register read mux
  always_comb begin
    off_s    = data_addr[11:2];
    access_s = data_req && (data_addr[31:12] == BASE_PAGE) && !gnt_q;
    rd_acc_s = access_s && !data_we;
    wr_acc_s = access_s && data_we;
    empty_s  = (count_q == {CW{1'b0}});
    full_s   = (count_q == DEPTH_C);
    pop_s    = rd_acc_s && (off_s == 10'd0) && !empty_s;
    w1c_s    = wr_acc_s && (off_s == 10'd2) && data_be[0];
    cnt3_s   = 3'(count_q);
    case (off_s)
      10'd0: begin
        if (empty_s) begin
          rd_val_s = 32'h0;
        end else begin
          rd_val_s = {23'h0, 1'b1, mem_q[rd_ptr_q]};
        end
      end
      10'd1:   rd_val_s = {29'h0, ctrl_q};
      10'd2:   rd_val_s = {24'h0, cnt3_s, overrun_q, frame_err_q, par_err_q, full_s, !empty_s};
      default: rd_val_s = 32'h0;
    endcase
  end

  // Receive FSM next state; rx_en low forces IDLE from any state
  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    stop_eval_s = 1'b0;
    if (!ctrl_q[0]) begin
      state_d = S_IDLE;
      cnt_d   = {TW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = {TW{1'b0}};
          if (!rx_s) begin
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d   = {TW{1'b0}};
            bcnt_d  = 3'd0;
            perr_d  = 1'b0;
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d           = {TW{1'b0}};
            shift_d[bcnt_q] = rx_s;
            if (bcnt_q == 3'd7) begin
              state_d = ctrl_q[1] ? S_PARITY : S_STOP;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = {TW{1'b0}};
            perr_d  = even_par_err(shift_q, rx_s);
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d       = {TW{1'b0}};
            stop_eval_s = 1'b1;
            state_d     = S_IDLE;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {TW{1'b0}};
        end
      endcase
    end
  end

  // FIFO, error flags and bus response; a pop frees the slot a same-edge push needs
  always_comb begin
    stop_ok_s = stop_eval_s && rx_s && !perr_q;
    stop_fe_s = stop_eval_s && !rx_s;
    stop_pe_s = stop_eval_s && rx_s && perr_q;
    push_s    = stop_ok_s && (!full_s || pop_s);
    ov_set_s  = stop_ok_s && full_s && !pop_s;
    wr_ptr_d  = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    par_err_d   = stop_pe_s || (par_err_q && !(w1c_s && data_wdata[2]));
    frame_err_d = stop_fe_s || (frame_err_q && !(w1c_s && data_wdata[3]));
    overrun_d   = ov_set_s || (overrun_q && !(w1c_s && data_wdata[4]));
    if (wr_acc_s && (off_s == 10'd1) && data_be[0]) begin
      ctrl_d = data_wdata[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end
    gnt_d    = access_s;
    rvalid_d = gnt_q;
    rdata_d  = rd_acc_s ? rd_val_s : rdata_q;
    irq_d    = ctrl_q[2] && (!empty_s || par_err_q || frame_err_q || overrun_q);
  end

  // Synchroniser and receive FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= {TW{1'b0}};
      bcnt_q  <= 3'd0;
      shift_q <= 8'h00;
      perr_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
    end
  end

  // FIFO storage, registers and bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      ctrl_q      <= 3'b000;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      gnt_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      irq_q       <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= shift_q;
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ctrl_q      <= ctrl_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed table, timing corner sequences, then random
// frames and bus traffic checked against a queue-based model of the register view.
module tb_uart_receiver;

  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
  localparam logic [19:0] BASE  = 20'h00024;
  // edge (counted from the edge that launches the start bit) on which an 8N1 push lands
  localparam int          PUSH_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [3:0]  data_be = 4'h0;
  logic [31:0] data_addr = 32'h0, data_wdata = 32'h0;
  logic        data_gnt, data_rvalid, irq;
  logic [31:0] data_rdata;
  logic        rx = 1'b1;

  uart_receiver #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_PAGE(BASE)) dut (
    .clk(clk), .rst(rst), .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .irq(irq), .rx(rx)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [1:0]  op;   // 0 frame, 1 read, 2 write
    logic [9:0]  off;
    logic [31:0] d;    // frame byte, write data or expected read data
    logic [3:0]  be;
    logic        hp, par, stop, miss, ci, ei;
  } vec_t;
  vec_t tbl[$];

  // reference model of the programmer-visible state
  logic [7:0] mq[$];
  logic       m_pe = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  logic [2:0] m_ctrl = 3'b000;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [9:0] off, input logic [31:0] wd,
                     input logic [3:0] be, input logic miss, output logic [31:0] rd,
                     output logic g1, output logic r1, output logic g2, output logic r2);
    data_req   = 1'b1;
    data_we    = we;
    data_addr  = {miss ? (BASE ^ 20'h00001) : BASE, off, 2'b00};
    data_wdata = wd;
    data_be    = be;
    @(posedge clk);
    #1;
    data_req = 1'b0;
    data_we  = 1'b0;
    g1 = data_gnt;
    r1 = data_rvalid;
    @(posedge clk);
    #1;
    g2 = data_gnt;
    r2 = data_rvalid;
    rd = data_rdata;
  endtask

  task automatic rd_chk(input logic [9:0] off, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    logic g1, r1, g2, r2;
    bus(1'b0, off, 32'h0, 4'hF, 1'b0, rd, g1, r1, g2, r2);
    check({nm, " gnt"}, {30'h0, g1, g2}, 32'h2);
    check({nm, " rvalid"}, {30'h0, r1, r2}, 32'h1);
    check(nm, rd, exp);
  endtask

  task automatic wr(input logic [9:0] off, input logic [31:0] wd, input logic [3:0] be,
                    input string nm);
    logic [31:0] rd;
    logic g1, r1, g2, r2;
    bus(1'b1, off, wd, be, 1'b0, rd, g1, r1, g2, r2);
    check({nm, " gnt/rvalid"}, {30'h0, g1, r2}, 32'h3);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic hp, input logic par,
                            input logic stop);
    rx = 1'b0;
    cycle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycle(CPB);
    end
    if (hp) begin
      rx = par;
      cycle(CPB);
    end
    rx = stop;
    cycle(CPB);
    rx = 1'b1;
  endtask

  function automatic void add(input logic [1:0] op, input logic [9:0] off, input logic [31:0] d,
                              input logic [3:0] be, input logic hp, input logic par,
                              input logic stop, input logic miss, input logic ci, input logic ei);
    vec_t v;
    v.op = op; v.off = off; v.d = d; v.be = be; v.hp = hp; v.par = par;
    v.stop = stop; v.miss = miss; v.ci = ci; v.ei = ei;
    tbl.push_back(v);
  endfunction

  function automatic void add_fr(input logic [7:0] b, input logic hp, input logic par, input logic stop);
    add(2'd0, 10'd0, {24'h0, b}, 4'h0, hp, par, stop, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic void add_rd(input logic [9:0] off, input logic [31:0] exp);
    add(2'd1, off, exp, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic void add_wr(input logic [9:0] off, input logic [31:0] wd, input logic [3:0] be,
                                 input logic ci, input logic ei);
    add(2'd2, off, wd, be, 1'b0, 1'b0, 1'b1, 1'b0, ci, ei);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[7:5] = 3'(mq.size());
    s[4] = m_ov;
    s[3] = m_fe;
    s[2] = m_pe;
    s[1] = (mq.size() == DEPTH);
    s[0] = (mq.size() != 0);
    return s;
  endfunction

  function automatic logic m_irq();
    return m_ctrl[2] && ((mq.size() != 0) || m_pe || m_fe || m_ov);
  endfunction

  function automatic void m_frame(input logic [7:0] b, input logic par, input logic stop);
    if (!m_ctrl[0]) return;
    if (!stop) m_fe = 1'b1;
    else if (m_ctrl[1] && ((^b) ^ par)) m_pe = 1'b1;
    else if (mq.size() == DEPTH) m_ov = 1'b1;
    else mq.push_back(b);
  endfunction

  initial begin
    logic [31:0] rd, exp, wd;
    logic g1, r1, g2, r2, par, stop;
    logic [7:0] b;
    logic [3:0] be;
    int sel;

    // directed table: expectations worked out by hand from the register description
    add_wr(10'd1, 32'h1, 4'hF, 1'b0, 1'b0);
    add_fr(8'hA5, 1'b0, 1'b0, 1'b1);
    add_rd(10'd2, 32'h21);
    add_rd(10'd0, 32'h1A5);
    add_rd(10'd0, 32'h0);
    add_rd(10'd2, 32'h0);
    add_fr(8'h11, 1'b0, 1'b0, 1'b1);
    add_fr(8'h22, 1'b0, 1'b0, 1'b1);
    add_fr(8'h33, 1'b0, 1'b0, 1'b1);
    add_fr(8'h44, 1'b0, 1'b0, 1'b1);
    add_fr(8'h55, 1'b0, 1'b0, 1'b1);
    add_rd(10'd2, 32'h93);
    add_rd(10'd0, 32'h111);
    add_rd(10'd0, 32'h122);
    add_rd(10'd0, 32'h133);
    add_rd(10'd0, 32'h144);
    add_rd(10'd2, 32'h10);
    add_wr(10'd2, 32'h10, 4'hF, 1'b0, 1'b0);
    add_rd(10'd2, 32'h0);
    add_wr(10'd1, 32'h3, 4'hF, 1'b0, 1'b0);
    add_fr(8'h03, 1'b1, 1'b1, 1'b1);
    add_rd(10'd2, 32'h04);
    add_rd(10'd0, 32'h0);
    add_fr(8'h03, 1'b1, 1'b0, 1'b1);
    add_rd(10'd2, 32'h25);
    add_rd(10'd0, 32'h103);
    add_wr(10'd2, 32'h04, 4'h1, 1'b0, 1'b0);
    add_rd(10'd2, 32'h0);
    add_wr(10'd1, 32'h1, 4'hF, 1'b0, 1'b0);
    add_fr(8'h5A, 1'b0, 1'b0, 1'b0);
    add_rd(10'd2, 32'h08);
    add_rd(10'd0, 32'h0);
    add_wr(10'd2, 32'h08, 4'hE, 1'b0, 1'b0);
    add_rd(10'd2, 32'h08);
    add_wr(10'd1, 32'h5, 4'hF, 1'b1, 1'b1);
    add_wr(10'd2, 32'h08, 4'h1, 1'b1, 1'b0);
    add_rd(10'd2, 32'h0);
    add_rd(10'd1, 32'h5);
    add_wr(10'd1, 32'h0, 4'hE, 1'b0, 1'b0);
    add_rd(10'd1, 32'h5);
    add_wr(10'd3, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
    add_rd(10'd3, 32'h0);
    add(2'd1, 10'd2, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // reset state
    cycle(3);
    check("reset gnt", {31'h0, data_gnt}, 32'h0);
    check("reset rvalid", {31'h0, data_rvalid}, 32'h0);
    check("reset rdata", data_rdata, 32'h0);
    check("reset irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    cycle(2);
    rd_chk(10'd2, 32'h0, "reset status");

    foreach (tbl[i]) begin
      case (tbl[i].op)
        2'd0: begin
          send_frame(tbl[i].d[7:0], tbl[i].hp, tbl[i].par, tbl[i].stop);
          cycle(2 * CPB);
        end
        2'd1: begin
          if (tbl[i].miss) begin
            bus(1'b0, tbl[i].off, 32'h0, tbl[i].be, 1'b1, rd, g1, r1, g2, r2);
            check($sformatf("tbl[%0d] miss gnt/rvalid", i), {28'h0, g1, r1, g2, r2}, 32'h0);
          end else begin
            rd_chk(tbl[i].off, tbl[i].d, $sformatf("tbl[%0d] read", i));
          end
        end
        default: wr(tbl[i].off, tbl[i].d, tbl[i].be, $sformatf("tbl[%0d] write", i));
      endcase
      if (tbl[i].ci) check($sformatf("tbl[%0d] irq", i), {31'h0, irq}, {31'h0, tbl[i].ei});
    end

    // short low glitch while idle is rejected; receiver still frames the next byte
    wr(10'd1, 32'h1, 4'hF, "glitch ctrl");
    rx = 1'b0;
    cycle(5);
    rx = 1'b1;
    cycle(3 * CPB);
    rd_chk(10'd2, 32'h0, "glitch status");
    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    cycle(2 * CPB);
    rd_chk(10'd0, 32'h177, "post-glitch byte");

    // rx_en dropped during data bit 3: nothing recorded
    fork
      send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
      begin
        cycle(11 + 3 * CPB + 4);
        wr(10'd1, 32'h0, 4'hF, "en-clear ctrl");
      end
    join
    cycle(2 * CPB);
    wr(10'd1, 32'h1, 4'hF, "en-set ctrl");
    rd_chk(10'd2, 32'h0, "en-clear status");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    cycle(2 * CPB);
    rd_chk(10'd0, 32'h13C, "post-en-clear byte");

    // full FIFO: push and pop on the same edge, no overrun
    for (int k = 0; k < 4; k++) begin
      send_frame(8'(8'h81 + k), 1'b0, 1'b0, 1'b1);
      cycle(2 * CPB);
    end
    rd_chk(10'd2, 32'h83, "full status");
    fork
      send_frame(8'h85, 1'b0, 1'b0, 1'b1);
      begin
        cycle(PUSH_EDGE - 1);
        rd_chk(10'd0, 32'h181, "full-pop head");
      end
    join
    cycle(2 * CPB);
    rd_chk(10'd2, 32'h83, "full-pop status");
    for (int k = 0; k < 4; k++) rd_chk(10'd0, 32'h182 + 32'(k), $sformatf("full-pop drain %0d", k));
    rd_chk(10'd2, 32'h0, "drained status");

    // asynchronous reset in the middle of a frame
    wr(10'd1, 32'h5, 4'hF, "rst ctrl");
    send_frame(8'h99, 1'b0, 1'b0, 1'b1);
    cycle(2 * CPB);
    rd_chk(10'd2, 32'h21, "pre-rst status");
    check("pre-rst irq", {31'h0, irq}, 32'h1);
    fork
      send_frame(8'h42, 1'b0, 1'b0, 1'b1);
      begin
        cycle(40);
        #3;
        rst = 1'b1;
        #1;
        check("async rst irq", {31'h0, irq}, 32'h0);
        check("async rst rdata", data_rdata, 32'h0);
        check("async rst gnt/rvalid", {30'h0, data_gnt, data_rvalid}, 32'h0);
        cycle(2);
        rst = 1'b0;
      end
    join
    cycle(2 * CPB);
    rd_chk(10'd1, 32'h0, "post-rst ctrl");
    wr(10'd1, 32'h1, 4'hF, "post-rst enable");
    cycle(2 * CPB);
    rd_chk(10'd2, 32'h0, "post-rst status");

    // random traffic against the model
    m_ctrl = 3'b001;
    for (int it = 0; it < 150; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        b = 8'($urandom);
        par = m_ctrl[1] ? ((^b) ^ ($urandom_range(0, 3) == 0)) : 1'b0;
        stop = ($urandom_range(0, 7) != 0);
        send_frame(b, m_ctrl[1], par, stop);
        cycle(2 * CPB);
        m_frame(b, par, stop);
      end else if (sel <= 5) begin
        exp = (mq.size() != 0) ? {23'h0, 1'b1, mq.pop_front()} : 32'h0;
        rd_chk(10'd0, exp, "rand rxdata");
      end else if (sel == 6) begin
        rd_chk(10'd2, m_status(), "rand status");
      end else if (sel == 7) begin
        wd = $urandom;
        be = 4'($urandom);
        wr(10'd2, wd, be, "rand w1c");
        if (be[0]) begin
          if (wd[2]) m_pe = 1'b0;
          if (wd[3]) m_fe = 1'b0;
          if (wd[4]) m_ov = 1'b0;
        end
      end else if (sel == 8) begin
        wd = {$urandom_range(0, 1) == 0 ? 29'h0 : 29'h1FFF_FFFF,
              1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) != 0)};
        be = ($urandom_range(0, 7) != 0) ? 4'h1 : 4'h0;
        wr(10'd1, wd, be, "rand ctrl");
        if (be[0]) m_ctrl = wd[2:0];
      end else begin
        rd_chk(10'd1, {29'h0, m_ctrl}, "rand ctrl read");
      end
      check($sformatf("rand irq %0d", it), {31'h0, irq}, {31'h0, m_irq()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
